// File: rtl/md_issue_ctrl_pkg.sv
// Shared constants for the MD issue controller: SPECIAL opcode, MD funct codes,
// default latencies and FSM state encodings.
package md_issue_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;
  localparam int SLACK_DEF    = 2;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    BUSY  = 2'd2
  } md_state_e;

  function automatic logic [CNT_W-1:0] lat_load(input logic is_div, input int mult_lat,
                                                input int div_lat, input int slack);
    lat_load = is_div ? CNT_W'(div_lat + slack) : CNT_W'(mult_lat + slack);
  endfunction

endpackage

// File: rtl/md_issue_ctrl_decode.sv
// Combinational MD class decoder: flags mult/div starts, div ops and HI/LO moves.
module md_class_decode
  import md_issue_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_start,
  output logic        is_div,
  output logic        is_rw
);

  logic unused_bits;
  assign unused_bits = ^instr[25:6];

  always_comb begin
    is_start = 1'b0;
    is_div   = 1'b0;
    is_rw    = 1'b0;
    if (instr[31:26] == OP_SPECIAL) begin
      case (instr[5:0])
        F_MULT, F_MULTU: is_start = 1'b1;
        F_DIV, F_DIVU: begin
          is_start = 1'b1;
          is_div   = 1'b1;
        end
        F_MFHI, F_MTHI, F_MFLO, F_MTLO: is_rw = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// D-stage issue control for the multiply/divide unit: stalls HI/LO users and
// checks busy timing. Optional stall counter enabled by MD_STALL_CNT_EN.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int SLACK    = SLACK_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  input  logic [31:0] instr_e,
  input  logic        md_start,
  input  logic        md_busy,
  output logic        stall_md,
  output logic        hilo_ready,
  output logic        md_err,
  output logic [31:0] stall_cycles
);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;

  logic d_start, d_rw, d_div_unused;
  logic e_div, e_start_unused, e_rw_unused;
  logic md_d;

  md_class_decode u_dec_d (
    .instr    (instr_d),
    .is_start (d_start),
    .is_div   (d_div_unused),
    .is_rw    (d_rw)
  );

  md_class_decode u_dec_e (
    .instr    (instr_e),
    .is_start (e_start_unused),
    .is_div   (e_div),
    .is_rw    (e_rw_unused)
  );

  assign md_d = valid_d & (d_start | d_rw);

  // Outputs are forced to their idle values while reset is held, regardless of inputs.
  assign stall_md   = reset_n & md_d & (md_start | md_busy | (state != IDLE));
  assign hilo_ready = ~reset_n | ((state == IDLE) & ~md_start & ~md_busy);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      md_err <= 1'b0;
    end else if (md_start) begin
      if (state != IDLE) md_err <= 1'b1;
      state <= ARMED;
      cnt   <= lat_load(e_div, MULT_LAT, DIV_LAT, SLACK);
    end else begin
      case (state)
        IDLE: ;
        ARMED: begin
          cnt <= (cnt != '0) ? cnt - CNT_W'(1) : '0;
          if (md_busy) begin
            state <= BUSY;
          end else begin
            state  <= IDLE;
            md_err <= 1'b1;
          end
        end
        BUSY: begin
          if (!md_busy) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            md_err <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MD_STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (stall_md && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed self-checking bench for md_issue_ctrl; expected values are hand-derived
// per cycle (cycle 0 = the md_start cycle of each scenario).
module tb_md_issue_ctrl;

  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [31:0] MULT    = 32'h0085_0018;
  localparam logic [31:0] MULTU   = 32'h0085_0019;
  localparam logic [31:0] DIV     = 32'h0085_001A;
  localparam logic [31:0] DIVU    = 32'h0085_001B;
  localparam logic [31:0] MFHI    = 32'h0000_4010;
  localparam logic [31:0] MTHI    = 32'h0100_0011;
  localparam logic [31:0] MFLO    = 32'h0000_4012;
  localparam logic [31:0] MTLO    = 32'h0100_0013;
  localparam logic [31:0] ADDU    = 32'h0085_4021;
  localparam logic [31:0] ADDI_LK = 32'h2000_4012;
  localparam logic [31:0] JR      = 32'h0100_0008;

`ifdef MD_STALL_CNT_EN
  localparam logic [31:0] T6_CNT = 32'd6;
`else
  localparam logic [31:0] T6_CNT = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr_d;
  logic        valid_d;
  logic [31:0] instr_e;
  logic        md_start;
  logic        md_busy;
  logic        stall_md;
  logic        hilo_ready;
  logic        md_err;
  logic [31:0] stall_cycles;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  md_issue_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instr_d      (instr_d),
    .valid_d      (valid_d),
    .instr_e      (instr_e),
    .md_start     (md_start),
    .md_busy      (md_busy),
    .stall_md     (stall_md),
    .hilo_ready   (hilo_ready),
    .md_err       (md_err),
    .stall_cycles (stall_cycles)
  );

  task automatic apply_stimulus(input logic [31:0] d, input logic vd, input logic [31:0] e,
                                input logic st, input logic bz);
    instr_d  = d;
    valid_d  = vd;
    instr_e  = e;
    md_start = st;
    md_busy  = bz;
    #4;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    apply_stimulus(NOP, 1'b0, NOP, 1'b0, 1'b0);
    reset_n = 1'b1;
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    apply_stimulus(MFLO, 1'b1, NOP, 1'b0, 1'b1);
    check_output("rst stall_md", stall_md, 1'b0);
    check_output("rst hilo_ready", hilo_ready, 1'b1);
    check_output("rst md_err", md_err, 1'b0);
    check_output("rst stall_cycles", stall_cycles, 32'd0);
    next_cycle();
    reset_n = 1'b1;
    apply_stimulus(NOP, 1'b0, NOP, 1'b0, 1'b0);
    next_cycle();

    // T1: mult in E, mflo waiting in D; busy high cycles 1..5, state IDLE at cycle 7
    for (int c = 0; c <= 7; c++) begin
      apply_stimulus(MFLO, 1'b1, (c == 0) ? MULT : NOP, c == 0, (c >= 1) && (c <= 5));
      check_output($sformatf("T1 stall c%0d", c), stall_md, c <= 6);
      check_output($sformatf("T1 hilo c%0d", c), hilo_ready, c == 7);
      next_cycle();
    end
    check_output("T1 md_err", md_err, 1'b0);

    // T2: div then independent addu; busy cycles 1..10
    for (int c = 0; c <= 12; c++) begin
      apply_stimulus(ADDU, 1'b1, (c == 0) ? DIV : NOP, c == 0, (c >= 1) && (c <= 10));
      check_output($sformatf("T2 stall c%0d", c), stall_md, 1'b0);
      check_output($sformatf("T2 hilo c%0d", c), hilo_ready, c == 12);
      next_cycle();
    end

    // T2b: div busy for exactly DIV_LAT+SLACK cycles is still tolerated
    for (int c = 0; c <= 14; c++) begin
      apply_stimulus(MFHI, 1'b1, (c == 0) ? DIV : NOP, c == 0, (c >= 1) && (c <= 12));
      check_output($sformatf("T2b stall c%0d", c), stall_md, c <= 13);
      next_cycle();
    end
    check_output("T2b md_err", md_err, 1'b0);

    // T3: busy held 13 cycles; error registered after the 13th busy cycle
    for (int c = 0; c <= 15; c++) begin
      apply_stimulus(MFLO, 1'b1, (c == 0) ? DIV : NOP, c == 0, (c >= 1) && (c <= 13));
      check_output($sformatf("T3 md_err c%0d", c), md_err, c >= 14);
      check_output($sformatf("T3 stall c%0d", c), stall_md, c <= 14);
      next_cycle();
    end

    do_reset();
    check_output("T4 md_err cleared", md_err, 1'b0);

    // T4: start with busy never rising
    for (int c = 0; c <= 2; c++) begin
      apply_stimulus(MFLO, 1'b1, (c == 0) ? MULT : NOP, c == 0, 1'b0);
      check_output($sformatf("T4 md_err c%0d", c), md_err, c == 2);
      check_output($sformatf("T4 stall c%0d", c), stall_md, c <= 1);
      check_output($sformatf("T4 hilo c%0d", c), hilo_ready, c == 2);
      next_cycle();
    end

    // T5: asynchronous reset in the middle of BUSY
    for (int c = 0; c <= 3; c++) begin
      apply_stimulus(MFLO, 1'b1, (c == 0) ? MULT : NOP, c == 0, c >= 1);
      if (c < 3) next_cycle();
    end
    check_output("T5 pre stall", stall_md, 1'b1);
    check_output("T5 pre hilo", hilo_ready, 1'b0);
    check_output("T5 pre md_err", md_err, 1'b1);
    reset_n = 1'b0;
    #1;
    check_output("T5 rst stall", stall_md, 1'b0);
    check_output("T5 rst hilo", hilo_ready, 1'b1);
    check_output("T5 rst md_err", md_err, 1'b0);
    check_output("T5 rst stall_cycles", stall_cycles, 32'd0);
    md_busy = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    apply_stimulus(MFHI, 1'b1, NOP, 1'b0, 1'b0);
    check_output("T5 post stall", stall_md, 1'b0);
    check_output("T5 post hilo", hilo_ready, 1'b1);
    next_cycle();

    // T6: mult with a bubble in D, mfhi arrives next cycle; stalls in cycles 1..6
    for (int c = 0; c <= 7; c++) begin
      apply_stimulus(MFHI, c >= 1, (c == 0) ? MULT : NOP, c == 0, (c >= 1) && (c <= 5));
      check_output($sformatf("T6 stall c%0d", c), stall_md, (c >= 1) && (c <= 6));
      next_cycle();
    end
    apply_stimulus(NOP, 1'b0, NOP, 1'b0, 1'b0);
    check_output("T6 stall_cycles", stall_cycles, T6_CNT);
    next_cycle();

    // T7: decode boundaries while a mult is in flight
    apply_stimulus(ADDI_LK, 1'b1, MULT, 1'b1, 1'b0);
    check_output("T7 non-special", stall_md, 1'b0);
    next_cycle();
    apply_stimulus(MFLO, 1'b0, NOP, 1'b0, 1'b1);
    check_output("T7 invalid mflo", stall_md, 1'b0);
    next_cycle();
    apply_stimulus(MTLO, 1'b1, NOP, 1'b0, 1'b1);
    check_output("T7 mtlo", stall_md, 1'b1);
    next_cycle();
    apply_stimulus(MULTU, 1'b1, NOP, 1'b0, 1'b1);
    check_output("T7 multu", stall_md, 1'b1);
    next_cycle();
    apply_stimulus(DIVU, 1'b1, NOP, 1'b0, 1'b1);
    check_output("T7 divu", stall_md, 1'b1);
    next_cycle();
    apply_stimulus(MTHI, 1'b1, NOP, 1'b0, 1'b0);
    check_output("T7 mthi", stall_md, 1'b1);
    next_cycle();
    apply_stimulus(JR, 1'b1, NOP, 1'b0, 1'b0);
    check_output("T7 jr", stall_md, 1'b0);
    check_output("T7 hilo", hilo_ready, 1'b1);
    check_output("T7 md_err", md_err, 1'b0);
    next_cycle();

    // T8: second start while BUSY flags an error and retracks the div
    for (int c = 0; c <= 14; c++) begin
      apply_stimulus(MFLO, 1'b1, (c == 0) ? MULT : ((c == 2) ? DIV : NOP),
                     (c == 0) || (c == 2), (c >= 1) && (c <= 12));
      check_output($sformatf("T8 md_err c%0d", c), md_err, c >= 3);
      check_output($sformatf("T8 stall c%0d", c), stall_md, c <= 13);
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
